// File: rtl/nn_pkg.sv
// Shared types and fixed-point helpers for the activation stage (activation_unit, hard_sigmoid).
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Default element width for the fixed-point vectors passed between layers.
  localparam int ELEM_W = 8;

  function automatic int fx_one(input int frac_bits);
    return 1 << frac_bits;
  endfunction

endpackage

// File: rtl/hard_sigmoid.sv
// Combinational hard sigmoid: y = clamp((x >>> 2) + 0.5, 0, 1.0) in signed fixed point.
module hard_sigmoid
  import nn_pkg::*;
#(
  parameter int resolution = ELEM_W,
  parameter int frac_bits  = 4
) (
  input  logic signed [resolution-1:0] x,
  output logic        [resolution-1:0] y
);

  localparam logic signed [resolution:0] ONE  = (resolution+1)'(fx_one(frac_bits));
  localparam logic signed [resolution:0] HALF = (resolution+1)'(fx_one(frac_bits) >> 1);

  function automatic logic [resolution-1:0] sat_unit(input logic signed [resolution:0] t);
    if (t[resolution]) return '0;
    if (t > ONE) return ONE[resolution-1:0];
    return t[resolution-1:0];
  endfunction

  // One guard bit keeps the shifted-plus-half sum from wrapping.
  logic signed [resolution:0] xe;
  logic signed [resolution:0] t;

  assign xe = {x[resolution-1], x};
  assign t  = (xe >>> 2) + HALF;
  assign y  = sat_unit(t);

endmodule

// File: rtl/activation_unit.sv
// Serial hard-sigmoid stage: captures a vector, evaluates one neuron per clock, hands off on valid/ready.
// Optional argmax tracker over the raw inputs is enabled with `define ACT_ARGMAX_EN.
module activation_unit
  import nn_pkg::*;
#(
  parameter int number_neuron = 30,
  parameter int resolution    = ELEM_W,
  parameter int frac_bits     = 4,
  localparam int IDX_W        = $clog2(number_neuron)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic signed [resolution*number_neuron-1:0] zed,
  output logic                                      busy,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic        [resolution*number_neuron-1:0] activation
`ifdef ACT_ARGMAX_EN
  ,
  output logic        [IDX_W-1:0]                   argmax_idx
`endif
);

  localparam int               VEC_W = resolution * number_neuron;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(number_neuron - 1);

  state_t                         state;
  logic   [IDX_W-1:0]             idx;
  logic   [VEC_W-1:0]             zed_p0;
  logic signed [resolution-1:0]   elem_p0;
  logic   [resolution-1:0]        act_p0;
  logic                           accept;

  assign accept  = in_valid && in_ready;
  assign elem_p0 = zed_p0[idx*resolution +: resolution];

  hard_sigmoid #(
    .resolution (resolution),
    .frac_bits  (frac_bits)
  ) u_hard_sigmoid (
    .x (elem_p0),
    .y (act_p0)
  );

  // Stage p0: captured vector feeds the shared sigmoid; result is written back at idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      zed_p0     <= '0;
      activation <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            zed_p0   <= zed;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          activation[idx*resolution +: resolution] <= act_p0;
          if (idx == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACT_ARGMAX_EN
  // Raw inputs are compared because saturated activations would tie; strict > keeps the lowest index.
  logic signed [resolution-1:0] max_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      max_p0     <= '0;
      argmax_idx <= '0;
    end else if (state == RUN && (idx == '0 || elem_p0 > max_p0)) begin
      max_p0     <= elem_p0;
      argmax_idx <= idx;
    end
  end
`endif

endmodule

// File: tb/tb_activation_unit.sv
// Self-checking bench for activation_unit (4 neurons, 8-bit, 4 fractional bits).
module tb_activation_unit;

  localparam int N  = 4;
  localparam int R  = 8;
  localparam int F  = 4;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [N*R-1:0] zed;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [N*R-1:0] activation;
`ifdef ACT_ARGMAX_EN
  logic [IW-1:0]  argmax_idx;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  activation_unit #(
    .number_neuron (N),
    .resolution    (R),
    .frac_bits     (F)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .zed        (zed),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .activation (activation)
`ifdef ACT_ARGMAX_EN
    ,
    .argmax_idx (argmax_idx)
`endif
  );

  typedef struct {
    logic [N*R-1:0] z;
    logic [N*R-1:0] a;
    int             am;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [N*R-1:0] pk(input int e0, input int e1, input int e2, input int e3);
    logic [N*R-1:0] r;
    r[0*R +: R] = R'(e0);
    r[1*R +: R] = R'(e1);
    r[2*R +: R] = R'(e2);
    r[3*R +: R] = R'(e3);
    return r;
  endfunction

  function automatic int elem(input logic [N*R-1:0] v, input int i);
    logic signed [R-1:0] e;
    e = v[i*R +: R];
    return int'(e);
  endfunction

  // Reference: quarter slope through 0.5, clamped to [0, 1.0]; floor division for the shift.
  function automatic int ref_hs(input int x);
    int q;
    int t;
    q = x / 4;
    if (x < 0 && (x % 4) != 0) q = q - 1;
    t = q + (1 << (F - 1));
    if (t < 0) return 0;
    if (t > (1 << F)) return 1 << F;
    return t;
  endfunction

  function automatic logic [N*R-1:0] ref_act(input logic [N*R-1:0] z);
    logic [N*R-1:0] a;
    a = '0;
    for (int i = 0; i < N; i++) a[i*R +: R] = R'(ref_hs(elem(z, i)));
    return a;
  endfunction

  function automatic int ref_argmax(input logic [N*R-1:0] z);
    int best;
    best = 0;
    for (int i = 1; i < N; i++)
      if (elem(z, i) > elem(z, best)) best = i;
    return best;
  endfunction

  task automatic run_vec(input logic [N*R-1:0] z, output int lat);
    int w;
    zed = z;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t           vecs[6];
  int             lat;
  int             acc[2];
  int             n;
  logic [N*R-1:0] va, vb, vc, vd, ve;

  initial begin
    vecs[0] = '{z: pk(0, 20, 64, -40),     a: pk(8, 13, 16, 0),  am: 2};
    vecs[1] = '{z: pk(127, 127, -128, 3),  a: pk(16, 16, 0, 8),  am: 0};
    vecs[2] = '{z: pk(-1, -4, 4, -33),     a: pk(7, 7, 9, 0),    am: 2};
    vecs[3] = '{z: pk(-32, 32, -128, 127), a: pk(0, 16, 0, 16),  am: 3};
    vecs[4] = '{z: pk(5, 5, 5, 5),         a: pk(9, 9, 9, 9),    am: 0};
    vecs[5] = '{z: pk(36, -35, 33, 31),    a: pk(16, 0, 16, 15), am: 0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; zed = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_activation", 64'(activation), 64'd0);
`ifdef ACT_ARGMAX_EN
    check("rst_argmax", 64'(argmax_idx), 64'd0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[k]) begin
      run_vec(vecs[k].z, lat);
      check($sformatf("vec%0d_latency", k), 64'(lat), 64'd4);
      check($sformatf("vec%0d_busy", k), 64'(busy), 64'd1);
      check($sformatf("vec%0d_activation", k), 64'(activation), 64'(vecs[k].a));
`ifdef ACT_ARGMAX_EN
      check($sformatf("vec%0d_argmax", k), 64'(argmax_idx), 64'(vecs[k].am));
`endif
      release_out();
    end

    // Backpressure: DONE must hold with a competing in_valid ignored.
    vc = pk(50, -7, 12, 90);
    run_vec(vc, lat);
    check("bp_latency", 64'(lat), 64'd4);
    zed = pk(1, 2, 3, 4);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_activation", 64'(activation), 64'(ref_act(vc)));
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    release_out();
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_hold", 64'(activation), 64'(ref_act(vc)));

    // Back-to-back: in_valid and out_ready both held high.
    va = pk(10, 20, 30, 40);
    vb = pk(-60, 70, -5, 15);
    zed = va; in_valid = 1'b1; out_ready = 1'b1; n = 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      logic hit;
      hit = in_valid && in_ready;
      if (hit) begin
        acc[n] = c;
        n++;
      end
      @(posedge clk); #1;
      if (hit && n == 1) zed = vb;
    end
    in_valid = 1'b0;
    check("b2b_accepts", 64'(n), 64'd2);
    check("b2b_spacing", 64'(acc[1] - acc[0]), 64'd6);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_latency", 64'(lat), 64'd4);
    check("b2b_activation", 64'(activation), 64'(ref_act(vb)));
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during the second RUN cycle.
    vd = pk(100, 100, 100, 100);
    @(posedge clk); #1;
    zed = vd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_activation", 64'(activation), 64'd0);
    ve = pk(-20, 44, 0, 8);
    run_vec(ve, lat);
    check("post_rst_latency", 64'(lat), 64'd4);
    check("post_rst_activation", 64'(activation), 64'(ref_act(ve)));
`ifdef ACT_ARGMAX_EN
    check("post_rst_argmax", 64'(argmax_idx), 64'(ref_argmax(ve)));
`endif
    release_out();

    // Randomized vectors against the reference model.
    for (int r = 0; r < 25; r++) begin
      logic [N*R-1:0] z;
      z = N*R'($urandom);
      if (r % 5 == 0) z[($urandom_range(0, N - 1))*R +: R] = (r % 10 == 0) ? 8'h7f : 8'h80;
      run_vec(z, lat);
      check("rnd_latency", 64'(lat), 64'd4);
      check("rnd_activation", 64'(activation), 64'(ref_act(z)));
`ifdef ACT_ARGMAX_EN
      check("rnd_argmax", 64'(argmax_idx), 64'(ref_argmax(z)));
`endif
      release_out();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
